// File: rtl/if_fetch_pc_unit.sv
// IF-stage PC register and single-outstanding fetch sequencer toward the inst SRAM-like bridge.
// Branch/jump targets take effect after the delay slot; a flush redirects the very next fetch.
module if_fetch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        BranchTakenD,
  input  logic [31:0] PCBranchD,
  input  logic        JumpD,
  input  logic [31:0] PCJumpD,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic        InstrValidF,
  input  logic        InstrReadyD,
  output logic [31:0] InstrF,
  output logic [31:0] PCF,
  output logic [31:0] PCPlus4F
);

  typedef enum logic [1:0] {
    stReq  = 2'd0,
    stWait = 2'd1,
    stHold = 2'd2
  } fetchState_t;

  fetchState_t state;

  logic [31:0] pcReg;
  logic        reqReg;
  logic [31:0] addrReg;
  logic        validReg;
  logic [31:0] instrReg;
  logic [31:0] pcfReg;
  logic [31:0] pcPlus4Reg;
  logic        redirPendReg;
  logic [31:0] redirPcReg;
  logic        discardReg;

  logic        redirIn;
  logic [31:0] redirTarget;
  logic [31:0] seqPc;
  logic [31:0] nextPc;

  assign redirIn     = BranchTakenD | JumpD;
  assign redirTarget = JumpD ? PCJumpD : PCBranchD;
  assign seqPc       = pcReg + 32'd4;

  // A redirect arriving in the same cycle the delay slot is accepted is applied directly.
  always_comb begin
    nextPc = seqPc;
    if (redirIn) begin
      nextPc = redirTarget;
    end else if (redirPendReg) begin
      nextPc = redirPcReg;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state        <= stReq;
      pcReg        <= RESET_PC;
      reqReg       <= 1'b0;
      addrReg      <= RESET_PC;
      validReg     <= 1'b0;
      instrReg     <= 32'd0;
      pcfReg       <= RESET_PC;
      pcPlus4Reg   <= RESET_PC + 32'd4;
      redirPendReg <= 1'b0;
      redirPcReg   <= 32'd0;
      discardReg   <= 1'b0;
    end else begin
      if (redirIn) begin
        redirPendReg <= 1'b1;
        redirPcReg   <= redirTarget;
      end

      case (state)
        stReq: begin
          // An address already on the bus cannot be withdrawn; its data is discarded later.
          if (flush) begin
            pcReg <= flush_pc;
            if (reqReg) begin
              discardReg <= 1'b1;
            end
          end
          if (!reqReg) begin
            reqReg  <= 1'b1;
            addrReg <= flush ? flush_pc : pcReg;
          end else if (inst_addr_ok) begin
            reqReg <= 1'b0;
            state  <= stWait;
          end
        end

        stWait: begin
          if (inst_data_ok) begin
            discardReg <= 1'b0;
            if (flush || discardReg) begin
              state <= stReq;
              if (flush) begin
                pcReg <= flush_pc;
              end
            end else begin
              instrReg   <= inst_rdata;
              pcfReg     <= addrReg;
              pcPlus4Reg <= addrReg + 32'd4;
              validReg   <= 1'b1;
              state      <= stHold;
            end
          end else if (flush) begin
            discardReg <= 1'b1;
            pcReg      <= flush_pc;
          end
        end

        stHold: begin
          if (flush) begin
            validReg <= 1'b0;
            pcReg    <= flush_pc;
            state    <= stReq;
          end else if (InstrReadyD) begin
            validReg     <= 1'b0;
            pcReg        <= nextPc;
            redirPendReg <= 1'b0;
            state        <= stReq;
          end
        end

        default: begin
          state <= stReq;
        end
      endcase

      if (flush) begin
        redirPendReg <= 1'b0;
      end
    end
  end

  assign inst_req    = reqReg;
  assign inst_addr   = addrReg;
  assign InstrValidF = validReg;
  assign InstrF      = instrReg;
  assign PCF         = pcfReg;
  assign PCPlus4F    = pcPlus4Reg;

endmodule

// File: tb/tb_if_fetch_pc_unit.sv
// Directed bench for if_fetch_pc_unit: a table of fetch transactions driven through a simple
// bridge model, plus hand-written reset sequences.
module tb_if_fetch_pc_unit;

  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        BranchTakenD = 1'b0;
  logic [31:0] PCBranchD = 32'd0;
  logic        JumpD = 1'b0;
  logic [31:0] PCJumpD = 32'd0;
  logic        flush = 1'b0;
  logic [31:0] flush_pc = 32'd0;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok = 1'b0;
  logic        inst_data_ok = 1'b0;
  logic [31:0] inst_rdata = 32'd0;
  logic        InstrValidF;
  logic        InstrReadyD = 1'b0;
  logic [31:0] InstrF;
  logic [31:0] PCF;
  logic [31:0] PCPlus4F;

  always #5 clock = ~clock;

  if_fetch_pc_unit #(.RESET_PC(RESET_PC)) dut (
    .clock        (clock),
    .resetn       (resetn),
    .BranchTakenD (BranchTakenD),
    .PCBranchD    (PCBranchD),
    .JumpD        (JumpD),
    .PCJumpD      (PCJumpD),
    .flush        (flush),
    .flush_pc     (flush_pc),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .InstrValidF  (InstrValidF),
    .InstrReadyD  (InstrReadyD),
    .InstrF       (InstrF),
    .PCF          (PCF),
    .PCPlus4F     (PCPlus4F)
  );

  // flushMode: 0 none, 1 flush in WAIT before data, 2 flush with data_ok, 3 flush in HOLD
  typedef struct {
    logic [31:0] expAddr;
    int          addrDelay;
    int          dataDelay;
    int          readyDelay;
    int          flushMode;
    logic [31:0] flushPc;
    logic        branch;
    logic        jump;
    logic [31:0] brTarget;
    logic [31:0] jTarget;
  } vec_t;

  int nVec = 0;
  int nMis = 0;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("FAIL %s: got %b required %b", name, act, exp);
    end else begin
      $display("ok   %s: %b", name, act);
    end
  endtask

  task automatic resetChecks(input string tag);
    chk1({tag, " inst_req"}, inst_req, 1'b0);
    chk1({tag, " InstrValidF"}, InstrValidF, 1'b0);
    chk({tag, " InstrF"}, InstrF, 32'd0);
    chk({tag, " PCF"}, PCF, RESET_PC);
    chk({tag, " PCPlus4F"}, PCPlus4F, RESET_PC + 32'd4);
    chk({tag, " inst_addr"}, inst_addr, RESET_PC);
  endtask

  task automatic waitReq(input string tag, output bit ok);
    int n;
    n = 0;
    while (inst_req !== 1'b1 && n < 30) begin
      @(negedge clock);
      n++;
    end
    ok = (inst_req === 1'b1);
    if (!ok) begin
      nVec++;
      nMis++;
      $display("FAIL %s req_timeout: inst_req=%b required 1 within 30 cycles", tag, inst_req);
    end
  endtask

  task automatic runVec(input vec_t v, input string tag);
    bit ok;
    logic [31:0] word;
    word = memWord(v.expAddr);
    waitReq(tag, ok);
    if (!ok) return;
    chk({tag, " inst_addr"}, inst_addr, v.expAddr);
    for (int i = 0; i < v.addrDelay; i++) begin
      @(negedge clock);
      chk1($sformatf("%s req_stable[%0d]", tag, i), inst_req, 1'b1);
      chk($sformatf("%s addr_stable[%0d]", tag, i), inst_addr, v.expAddr);
    end
    inst_addr_ok = 1'b1;
    @(negedge clock);
    inst_addr_ok = 1'b0;
    chk1({tag, " req_dropped"}, inst_req, 1'b0);
    if (v.flushMode == 1) begin
      flush = 1'b1;
      flush_pc = v.flushPc;
      @(negedge clock);
      flush = 1'b0;
    end else begin
      for (int i = 0; i < v.dataDelay; i++) @(negedge clock);
    end
    inst_data_ok = 1'b1;
    inst_rdata = word;
    if (v.flushMode == 2) begin
      flush = 1'b1;
      flush_pc = v.flushPc;
    end
    @(negedge clock);
    inst_data_ok = 1'b0;
    inst_rdata = 32'd0;
    flush = 1'b0;
    if (v.flushMode == 1 || v.flushMode == 2) begin
      chk1({tag, " discarded_not_valid"}, InstrValidF, 1'b0);
      return;
    end
    chk1({tag, " InstrValidF"}, InstrValidF, 1'b1);
    chk({tag, " InstrF"}, InstrF, word);
    chk({tag, " PCF"}, PCF, v.expAddr);
    chk({tag, " PCPlus4F"}, PCPlus4F, v.expAddr + 32'd4);
    for (int i = 0; i < v.readyDelay; i++) begin
      @(negedge clock);
      chk($sformatf("%s hold_InstrF[%0d]", tag, i), InstrF, word);
      chk($sformatf("%s hold_PCF[%0d]", tag, i), PCF, v.expAddr);
      chk1($sformatf("%s hold_noreq[%0d]", tag, i), inst_req, 1'b0);
    end
    if (v.flushMode == 3) begin
      flush = 1'b1;
      flush_pc = v.flushPc;
      @(negedge clock);
      flush = 1'b0;
      chk1({tag, " hold_flush_drop"}, InstrValidF, 1'b0);
      return;
    end
    InstrReadyD = 1'b1;
    @(negedge clock);
    InstrReadyD = 1'b0;
    chk1({tag, " accepted"}, InstrValidF, 1'b0);
    if (v.branch || v.jump) begin
      BranchTakenD = v.branch;
      JumpD = v.jump;
      PCBranchD = v.brTarget;
      PCJumpD = v.jTarget;
      @(negedge clock);
      BranchTakenD = 1'b0;
      JumpD = 1'b0;
    end
  endtask

  function automatic vec_t mk(input logic [31:0] a, input int ad, input int dd, input int rd,
                              input int fm, input logic [31:0] fpc, input logic br,
                              input logic jp, input logic [31:0] bt, input logic [31:0] jt);
    vec_t v;
    v.expAddr = a; v.addrDelay = ad; v.dataDelay = dd; v.readyDelay = rd;
    v.flushMode = fm; v.flushPc = fpc; v.branch = br; v.jump = jp;
    v.brTarget = bt; v.jTarget = jt;
    return v;
  endfunction

  vec_t tbl[15];
  vec_t seq[6];

  initial begin
    bit ok;
    tbl[0]  = mk(32'hBFC0_0000, 0, 0, 0, 0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    tbl[1]  = mk(32'hBFC0_0004, 1, 1, 0, 0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    tbl[2]  = mk(32'hBFC0_0008, 0, 0, 0, 0, 32'd0, 1'b1, 1'b0, 32'hBFC0_0100, 32'd0);
    tbl[3]  = mk(32'hBFC0_000C, 0, 0, 0, 0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    tbl[4]  = mk(32'hBFC0_0100, 0, 0, 5, 0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    tbl[5]  = mk(32'hBFC0_0104, 10, 0, 0, 0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    tbl[6]  = mk(32'hBFC0_0108, 0, 0, 0, 0, 32'd0, 1'b0, 1'b1, 32'd0, 32'hFFFF_FFFC);
    tbl[7]  = mk(32'hBFC0_010C, 0, 3, 0, 0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    tbl[8]  = mk(32'hFFFF_FFFC, 0, 0, 0, 0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    tbl[9]  = mk(32'h0000_0000, 0, 0, 0, 0, 32'd0, 1'b1, 1'b1, 32'h0000_2000, 32'h0000_1002);
    tbl[10] = mk(32'h0000_0004, 0, 0, 0, 0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    tbl[11] = mk(32'h0000_1002, 0, 0, 0, 0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    tbl[12] = mk(32'h0000_1006, 0, 0, 0, 2, 32'h8000_0180, 1'b0, 1'b0, 32'd0, 32'd0);
    tbl[13] = mk(32'h8000_0180, 0, 0, 0, 3, 32'hBFC0_0380, 1'b0, 1'b0, 32'd0, 32'd0);
    tbl[14] = mk(32'hBFC0_0380, 0, 1, 0, 0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);

    seq[0] = mk(32'hBFC0_0000, 0, 0, 0, 0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    seq[1] = mk(32'hBFC0_0004, 0, 0, 0, 0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    seq[2] = mk(32'hBFC0_0008, 0, 0, 0, 0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    seq[3] = mk(32'hBFC0_000C, 0, 0, 0, 0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    seq[4] = mk(32'hBFC0_0010, 0, 0, 0, 1, 32'hBFC0_0380, 1'b0, 1'b0, 32'd0, 32'd0);
    seq[5] = mk(32'hBFC0_0000, 0, 0, 0, 0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);

    // Power-on reset held across a few edges.
    #32;
    resetChecks("por");
    @(negedge clock);
    resetn = 1'b1;
    chk1("por first_cycle_noreq", inst_req, 1'b0);
    @(negedge clock);
    chk1("por req_rises", inst_req, 1'b1);

    for (int i = 0; i < 15; i++) begin
      runVec(tbl[i], $sformatf("tbl%0d", i));
    end

    // Fresh reset, then flush while waiting on the fetch of 0xBFC00010.
    @(negedge clock);
    resetn = 1'b0;
    @(negedge clock);
    @(negedge clock);
    resetn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      runVec(seq[i], $sformatf("seq%0d", i));
    end

    // Reset asserted while the fetch at the flush target sits in WAIT.
    waitReq("midwait", ok);
    if (ok) begin
      chk("midwait inst_addr", inst_addr, 32'hBFC0_0380);
      inst_addr_ok = 1'b1;
      @(negedge clock);
      inst_addr_ok = 1'b0;
      chk1("midwait in_wait", inst_req, 1'b0);
      resetn = 1'b0;
      #1;
      resetChecks("midwait_rst");
      @(negedge clock);
      @(negedge clock);
      resetn = 1'b1;
      runVec(seq[5], "post_rst");
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
